// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP bias datapath.
//   BIAS_W          - bias word width (two bytes per word)
//   BIAS2_DEPTH     - number of layer-2 bias entries (one per output neuron)
//   bias_t          - one bias word
//   bias_ld_state_e - bias loader FSM states
package mlp_pkg;

  localparam int unsigned BIAS_W      = 16;
  localparam int unsigned BIAS2_DEPTH = 10;

  typedef logic [15:0] bias_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } bias_ld_state_e;

endpackage

// File: rtl/bias_rf_1w1r.sv
// Bias register file: DEPTH x DATA_W words, synchronously reset to zero.
// Ports:
//   clk, reset - rising-edge clock, synchronous active-high reset
//   we, wa, wd - synchronous write port
//   ra, rd     - combinational read port; rd is 0 for ra >= DEPTH
module bias_rf_1w1r #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wa == ADDR_W'(i)) begin
          mem[i] <= wd;
        end
      end
    end
  end

  // Decoded read: addresses without a backing entry fall through to zero
  // instead of indexing past the array.
  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ra == ADDR_W'(i)) begin
        rd = mem[i];
      end
    end
  end

endmodule

// File: rtl/bias2_loader.sv
// Layer-2 bias table loader. Accepts a byte stream over valid/ready,
// assembles 16-bit words low byte first and writes them sequentially into
// a reloadable bias register file with a combinational read port.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   start            - pulse; begin or restart a full table load
//   in_valid/in_data - byte stream input
//   in_ready         - byte accepted this cycle when in_valid is high
//   busy             - load in progress
//   loaded           - all DEPTH entries written since last start/reset
//   overflow_err     - sticky; byte offered after the table was full
//   ra1, rd1         - combinational bias read port
module bias2_loader
  import mlp_pkg::*;
#(
  parameter int unsigned DATA_W = BIAS_W,
  parameter int unsigned DEPTH  = BIAS2_DEPTH,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              loaded,
  output logic              overflow_err,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  bias_ld_state_e    state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        lo_byte;
  logic              hs;
  logic              we;
  logic [DATA_W-1:0] wd;

  assign in_ready = (state == LO) || (state == HI);
  assign busy     = in_ready;
  assign loaded   = (state == DONE);
  assign hs       = in_valid && in_ready;

  // start outranks a coincident handshake, so the write is masked too.
  assign we = (state == HI) && hs && !start;
  assign wd = {in_data, lo_byte};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      lo_byte      <= '0;
      overflow_err <= 1'b0;
    end else if (start) begin
      state        <= LO;
      wr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        LO: begin
          if (hs) begin
            lo_byte <= in_data;
            state   <= HI;
          end
        end
        HI: begin
          if (hs) begin
            if (wr_ptr == LAST) begin
              state <= DONE;
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
              state  <= LO;
            end
          end
        end
        DONE: begin
          if (in_valid) begin
            overflow_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bias_rf_1w1r #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rf (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .wa   (wr_ptr),
    .wd   (wd),
    .ra   (ra1),
    .rd   (rd1)
  );

endmodule

// File: tb/tb_bias2_loader.sv
module tb_bias2_loader;
  import mlp_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        busy;
  logic        loaded;
  logic        overflow_err;
  logic [5:0]  ra1;
  logic [15:0] rd1;

  int checks;
  int errors;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [12];

  bias2_loader #(
    .DATA_W(16),
    .DEPTH (10),
    .ADDR_W(6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .loaded      (loaded),
    .overflow_err(overflow_err),
    .ra1         (ra1),
    .rd1         (rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [5:0] addr, input logic [15:0] exp);
    ra1 = addr;
    @(negedge clk);
    check(name, {16'h0, rd1}, {16'h0, exp});
  endtask

  task automatic read_all(input string name, input logic [15:0] exp);
    for (int k = 0; k < 10; k++) begin
      read_check(name, 6'(k), exp);
    end
  endtask

  // Offer one byte, leave in_valid high afterwards; returns stall cycles.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int stalls);
    stalls = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && stalls < 50) begin
      tick();
      stalls++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    else tick();
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    int s;
    send_byte(w[7:0], gaps, s);
    send_byte(w[15:8], gaps, s);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int stalls;
    int total_stalls;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ra1      = '0;

    for (int k = 0; k < 10; k++) begin
      vecs[k].addr = 6'(k);
      vecs[k].exp  = 16'(k + 1);
    end
    vecs[10].addr = 6'd10; vecs[10].exp = 16'h0000;
    vecs[11].addr = 6'd63; vecs[11].exp = 16'h0000;

    // 1: reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_ovf", {31'd0, overflow_err}, 32'd0);
    read_all("rst_table", 16'h0000);

    // idle bytes are ignored without error
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_ovf", {31'd0, overflow_err}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    read_check("idle_table", 6'd0, 16'h0000);

    // 2: back-to-back load of k+1
    pulse_start();
    check("ld_busy", {31'd0, busy}, 32'd1);
    total_stalls = 0;
    for (int k = 0; k < 10; k++) begin
      send_byte(8'(k + 1), 1'b0, stalls);
      total_stalls += stalls;
      send_byte(8'h00, 1'b0, stalls);
      total_stalls += stalls;
    end
    in_valid = 1'b0;
    check("ld_stalls", total_stalls, 32'd0);
    check("ld_loaded", {31'd0, loaded}, 32'd1);
    check("ld_ready_off", {31'd0, in_ready}, 32'd0);
    check("ld_busy_off", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      read_check("ld_table", vecs[i].addr, vecs[i].exp);
    end

    // 3: load with random gaps
    pulse_start();
    check("gap_loaded_drop", {31'd0, loaded}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      send_word(16'h1234, 1'b1);
    end
    check("gap_loaded", {31'd0, loaded}, 32'd1);
    read_all("gap_table", 16'h1234);

    // 4: overflow in DONE
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    check("ovf_set", {31'd0, overflow_err}, 32'd1);
    tick();
    check("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    check("ovf_loaded", {31'd0, loaded}, 32'd1);
    read_all("ovf_table", 16'h1234);
    pulse_start();
    check("ovf_clear", {31'd0, overflow_err}, 32'd0);
    check("ovf_busy", {31'd0, busy}, 32'd1);

    // 5: restart mid-word with coincident byte
    for (int k = 0; k < 3; k++) begin
      send_word({8'(8'hC0 + k), 8'(8'h50 + k)}, 1'b0);
    end
    send_byte(8'h53, 1'b0, stalls);
    in_valid = 1'b0;
    read_check("part_e0", 6'd0, 16'hC050);
    read_check("part_e2", 6'd2, 16'hC252);
    read_check("part_e3", 6'd3, 16'h1234);
    in_valid = 1'b1;
    in_data  = 8'h77;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("rs_busy", {31'd0, busy}, 32'd1);
    read_check("rs_e3_kept", 6'd3, 16'h1234);
    send_word(16'hAA55, 1'b0);
    read_check("rs_e0_new", 6'd0, 16'hAA55);
    read_check("rs_e1_old", 6'd1, 16'hC151);
    for (int k = 1; k < 10; k++) begin
      send_word(16'hAA55, 1'b0);
    end
    check("rs_loaded", {31'd0, loaded}, 32'd1);
    read_all("rs_table", 16'hAA55);

    // 6: write latency, then reset mid-load
    pulse_start();
    send_byte(8'h11, 1'b0, stalls);
    in_data = 8'h22;
    ra1     = 6'd0;
    #1;
    check("wl_old", {16'h0, rd1}, {16'h0, 16'hAA55});
    tick();
    in_valid = 1'b0;
    check("wl_new", {16'h0, rd1}, {16'h0, 16'h2211});
    for (int k = 1; k < 5; k++) begin
      send_word(16'h3300 + 16'(k), 1'b0);
    end
    read_check("pre_rst_e4", 6'd4, 16'h3304);
    read_check("pre_rst_e5", 6'd5, 16'hAA55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_loaded", {31'd0, loaded}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd0);
    read_all("mrst_table", 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
